// File: rtl/prio_enc_queue.sv
// prio_enc_queue: priority / round-robin request encoder feeding a result FIFO.
// A one-stage encode register decouples put acceptance from the FIFO write.
module prio_enc_queue #(
    parameter int NUM_IN = 8,
    parameter int MODE   = 0,
    parameter int DEPTH  = 4
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         EN_put,
    input  logic [NUM_IN-1:0]            mav_putvalue_req,
    output logic                         RDY_put,
    input  logic                         EN_get,
    output logic                         RDY_get,
    output logic [$clog2(NUM_IN)-1:0]    mv_index,
    output logic                         mv_none,
    output logic [$clog2(DEPTH+1)-1:0]   mv_count
);
    localparam int IDX_W = $clog2(NUM_IN);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);

    logic                r_vld_q, r_vld_d;
    logic [NUM_IN-1:0]   r_req_q, r_req_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W:0]      mem_q [DEPTH];

    logic                push, pop, acc;
    logic [IDX_W-1:0]    fp_idx, rr_off, rr_idx, rr_next, enc_idx;
    logic                enc_none;
    logic [2*NUM_IN-1:0] req_dbl;
    logic [IDX_W:0]      rr_sum, rr_wrap;

    assign RDY_put  = ({1'b0, count_q} + (CNT_W+1)'(r_vld_q)) < (CNT_W+1)'(DEPTH);
    assign RDY_get  = count_q != '0;
    assign mv_count = count_q;
    assign mv_index = RDY_get ? mem_q[rd_ptr_q][IDX_W-1:0] : '0;
    assign mv_none  = RDY_get ? mem_q[rd_ptr_q][IDX_W] : 1'b0;

    assign acc  = EN_put && RDY_put;
    assign pop  = EN_get && RDY_get;
    assign push = r_vld_q;

    always_comb begin
        fp_idx = '0;
        for (int i = 0; i < NUM_IN; i++)
            if (r_req_q[i]) fp_idx = IDX_W'(i);
    end

    // Rotate so bit rr_ptr sits at position 0, then take the lowest set bit.
    assign req_dbl = {r_req_q, r_req_q} >> rr_ptr_q;

    always_comb begin
        rr_off = '0;
        for (int i = NUM_IN - 1; i >= 0; i--)
            if (req_dbl[i]) rr_off = IDX_W'(i);
    end

    assign rr_sum   = {1'b0, rr_ptr_q} + {1'b0, rr_off};
    assign rr_wrap  = rr_sum - (IDX_W+1)'(NUM_IN);
    assign rr_idx   = rr_sum >= (IDX_W+1)'(NUM_IN) ? rr_wrap[IDX_W-1:0] : rr_sum[IDX_W-1:0];
    assign rr_next  = rr_idx == IDX_W'(NUM_IN - 1) ? '0 : rr_idx + 1'b1;
    assign enc_none = ~|r_req_q;
    assign enc_idx  = enc_none ? '0 : (MODE == 1 ? rr_idx : fp_idx);

    always_comb begin
        r_vld_d  = acc;
        r_req_d  = acc ? mav_putvalue_req : r_req_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        rr_ptr_d = (MODE == 1 && push && !enc_none) ? rr_next : rr_ptr_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_vld_q  <= 1'b0;
            r_req_q  <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            r_vld_q  <= r_vld_d;
            r_req_q  <= r_req_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Storage needs no reset: the head outputs are masked while empty.
    always_ff @(posedge CLK)
        if (push) mem_q[wr_ptr_q] <= {enc_none, enc_idx};
endmodule

// File: tb/tb_prio_enc_queue.sv
// tb_prio_enc_queue: scoreboard bench running a fixed-priority and a round-robin instance
// side by side on identical stimulus.
module tb_prio_enc_queue;
    logic       CLK = 1'b0, RST_N = 1'b0, EN_put = 1'b0, EN_get = 1'b0;
    logic [7:0] req = '0;
    logic       rdy_put0, rdy_get0, none0, rdy_put1, rdy_get1, none1;
    logic [2:0] idx0, cnt0, idx1, cnt1;

    int         n_chk = 0, n_fail = 0;
    int         m_cnt = 0, m_vld = 0, m_rr = 0;
    logic [3:0] q0[$], q1[$], pop1[$];

    always #5 CLK = ~CLK;

    prio_enc_queue #(.NUM_IN(8), .MODE(0), .DEPTH(4)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .EN_put(EN_put), .mav_putvalue_req(req), .RDY_put(rdy_put0),
        .EN_get(EN_get), .RDY_get(rdy_get0), .mv_index(idx0), .mv_none(none0), .mv_count(cnt0));

    prio_enc_queue #(.NUM_IN(8), .MODE(1), .DEPTH(4)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .EN_put(EN_put), .mav_putvalue_req(req), .RDY_put(rdy_put1),
        .EN_get(EN_get), .RDY_get(rdy_get1), .mv_index(idx1), .mv_none(none1), .mv_count(cnt1));

    // One clock of stimulus; outputs are sampled mid-cycle and checked against the model.
    task automatic cycle(input logic p, input logic [7:0] r, input logic g);
        logic       rdy, acc, pop;
        logic [3:0] e0, e1, h0, h1;
        @(negedge CLK);
        EN_put = p; req = r; EN_get = g;
        #1;
        rdy = (m_cnt + m_vld) < 4;
        acc = p && rdy;
        pop = g && m_cnt > 0;
        n_chk++;
        if (rdy_put0 !== rdy || rdy_put1 !== rdy) begin
            n_fail++;
            $display("FAIL rdy_put: got %b/%b expected %b", rdy_put0, rdy_put1, rdy);
        end
        n_chk++;
        if (rdy_get0 !== (m_cnt > 0) || rdy_get1 !== (m_cnt > 0)) begin
            n_fail++;
            $display("FAIL rdy_get: got %b/%b expected %b", rdy_get0, rdy_get1, m_cnt > 0);
        end
        n_chk++;
        if (cnt0 !== 3'(m_cnt) || cnt1 !== 3'(m_cnt)) begin
            n_fail++;
            $display("FAIL count: got %0d/%0d expected %0d", cnt0, cnt1, m_cnt);
        end
        h0 = m_cnt > 0 ? q0[0] : 4'h0;
        h1 = m_cnt > 0 ? q1[0] : 4'h0;
        n_chk++;
        if ({none0, idx0} !== h0) begin
            n_fail++;
            $display("FAIL head_mode0: got none=%b idx=%0d expected none=%b idx=%0d", none0, idx0, h0[3], h0[2:0]);
        end
        n_chk++;
        if ({none1, idx1} !== h1) begin
            n_fail++;
            $display("FAIL head_mode1: got none=%b idx=%0d expected none=%b idx=%0d", none1, idx1, h1[3], h1[2:0]);
        end
        if (pop) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
            pop1.push_back({none1, idx1});
        end
        if (acc) begin
            e0 = 4'b1000;
            for (int i = 0; i < 8; i++)
                if (r[i]) e0 = {1'b0, 3'(i)};
            e1 = 4'b1000;
            for (int k = 0; k < 8; k++) begin
                int gi;
                gi = (m_rr + k) % 8;
                if (r[gi] && e1[3]) begin
                    e1 = {1'b0, 3'(gi)};
                    m_rr = (gi + 1) % 8;
                end
            end
            q0.push_back(e0);
            q1.push_back(e1);
        end
        m_cnt = m_cnt + m_vld - int'(pop);
        m_vld = int'(acc);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        EN_put = 1'b0; EN_get = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        n_chk++;
        if (rdy_put0 !== 1'b1 || rdy_put1 !== 1'b1 || rdy_get0 !== 1'b0 || rdy_get1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rdy: got put=%b/%b get=%b/%b expected put=1 get=0", rdy_put0, rdy_put1, rdy_get0, rdy_get1);
        end
        n_chk++;
        if (cnt0 !== 3'd0 || cnt1 !== 3'd0 || {none0, idx0} !== 4'h0 || {none1, idx1} !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cnt=%0d/%0d head=%h/%h expected 0", cnt0, cnt1, {none0, idx0}, {none1, idx1});
        end
        q0.delete(); q1.delete();
        m_cnt = 0; m_vld = 0; m_rr = 0;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        cycle(0, 8'h00, 0);
    endtask

    task automatic test_basic();
        cycle(1, 8'b0010_1100, 0);
        cycle(0, 8'h00, 0);
        cycle(0, 8'h00, 0);
        n_chk++;
        if (idx0 !== 3'd5 || none0 !== 1'b0 || rdy_get0 !== 1'b1 || cnt0 !== 3'd1) begin
            n_fail++;
            $display("FAIL basic_mode0: got idx=%0d none=%b rdy=%b cnt=%0d expected 5 0 1 1", idx0, none0, rdy_get0, cnt0);
        end
        cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 0);
    endtask

    task automatic test_zero();
        cycle(1, 8'h00, 0);
        cycle(0, 8'h00, 0);
        cycle(0, 8'h00, 0);
        n_chk++;
        if (none0 !== 1'b1 || none1 !== 1'b1 || idx0 !== 3'd0 || idx1 !== 3'd0) begin
            n_fail++;
            $display("FAIL zero_req: got none=%b/%b idx=%0d/%0d expected 1 and 0", none0, none1, idx0, idx1);
        end
        cycle(0, 8'h00, 1);
        cycle(1, 8'h80, 1);
        cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 1);
    endtask

    task automatic test_rr();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1};
        do_reset();
        pop1.delete();
        cycle(1, 8'hFF, 1);
        cycle(1, 8'hFF, 1);
        cycle(1, 8'hFF, 1);
        cycle(1, 8'h01, 1);
        cycle(1, 8'hFF, 1);
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1);
        n_chk++;
        if (pop1.size() != 5) begin
            n_fail++;
            $display("FAIL rr_pop_count: got %0d expected 5", pop1.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_chk++;
                if (pop1[i] !== exp_seq[i]) begin
                    n_fail++;
                    $display("FAIL rr_seq[%0d]: got %h expected %h", i, pop1[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 6; i++) cycle(1, 8'($urandom), 0);
        cycle(0, 8'h00, 0);
        n_chk++;
        if (cnt0 !== 3'd4 || rdy_put0 !== 1'b0 || rdy_put1 !== 1'b0) begin
            n_fail++;
            $display("FAIL full: got cnt=%0d rdy_put=%b/%b expected 4 0", cnt0, rdy_put0, rdy_put1);
        end
        cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 0);
        n_chk++;
        if (rdy_put0 !== 1'b1 || cnt0 !== 3'd3) begin
            n_fail++;
            $display("FAIL after_get: got rdy_put=%b cnt=%0d expected 1 3", rdy_put0, cnt0);
        end
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            cycle(1, 8'($urandom), 1);
            n_chk++;
            if (cnt0 > 3'd1 || cnt1 > 3'd1) begin
                n_fail++;
                $display("FAIL stream_count: got %0d/%0d expected <=1", cnt0, cnt1);
            end
        end
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1);
    endtask

    task automatic test_reset_mid();
        cycle(1, 8'h11, 0);
        cycle(1, 8'h22, 0);
        cycle(1, 8'h44, 0);
        cycle(0, 8'h00, 0);
        cycle(0, 8'h00, 0);
        n_chk++;
        if (cnt0 !== 3'd3) begin
            n_fail++;
            $display("FAIL pre_reset_count: got %0d expected 3", cnt0);
        end
        do_reset();
        cycle(1, 8'h40, 0);
        cycle(0, 8'h00, 0);
        cycle(0, 8'h00, 0);
        n_chk++;
        if (idx0 !== 3'd6 || idx1 !== 3'd6 || cnt0 !== 3'd1) begin
            n_fail++;
            $display("FAIL post_reset_put: got idx=%0d/%0d cnt=%0d expected 6 6 1", idx0, idx1, cnt0);
        end
        cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_rr();
        test_full();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
